// File: rtl/uart_tx_word_assembler.sv
// UART 8N1 receiver feeding a framed-word assembler (sync 0xA5, 4 data bytes MSB first, XOR checksum)
// with a single-entry valid/ready output register and saturating error counters.
module uart_tx_word_assembler #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [31:0] Tx_data,
    output logic        Tx_valid,
    input  logic        Tx_ready,
    output logic [7:0]  chk_err_cnt,
    output logic [7:0]  frame_err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TMR_W        = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HUNT, B3, B2, B1, B0, CHK} asm_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---------------- input synchroniser ----------------
    logic       rx_meta, rx_sync, rx_prev, rx_armed;
    logic [1:0] sync_vld;
    logic       rx_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_meta, rx_sync, rx_prev} <= 3'b111;
            sync_vld <= 2'b00;
            rx_armed <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            sync_vld <= {sync_vld[0], 1'b1};
            // Arm only once a real line high has reached rx_sync, so a line held low through reset is ignored.
            if (sync_vld[1] && rx_sync)
                rx_armed <= 1'b1;
        end
    end

    assign rx_fall = rx_armed && rx_prev && !rx_sync;

    // ---------------- byte receiver ----------------
    rx_state_t             rx_state, rx_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            rx_shift;
    logic                  sample;
    logic                  byte_stb, byte_err;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rx_next = rx_state;
        sample  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (bit_cnt == BIT_CNT_W'(HALF_BIT - 1)) begin
                sample  = 1'b1;
                rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
                sample = 1'b1;
                if (bit_idx == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP:  if (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
                sample  = 1'b1;
                rx_next = RX_IDLE;
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            byte_stb <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            rx_state <= rx_next;
            byte_stb <= 1'b0;
            byte_err <= 1'b0;
            if (rx_state == RX_IDLE || sample) bit_cnt <= '0;
            else                               bit_cnt <= bit_cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && sample) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
            if (rx_state == RX_STOP && sample) begin
                byte_stb <= rx_sync;
                byte_err <= !rx_sync;
            end
        end
    end

    // ---------------- frame assembler ----------------
    asm_state_t        asm_state, asm_next;
    logic [31:0]       shadow;
    logic [7:0]        xor_acc;
    logic [TMR_W-1:0]  tmr;
    logic              frame_good, chk_bad, timeout;

    always_comb begin
        asm_next   = asm_state;
        frame_good = 1'b0;
        chk_bad    = 1'b0;
        timeout    = (asm_state != HUNT) && (tmr == TMR_W'(TIMEOUT_CLKS - 1));
        if (byte_err) begin
            asm_next = HUNT;
        end else if (byte_stb) begin
            case (asm_state)
                HUNT:    if (rx_shift == SYNC_BYTE) asm_next = B3;
                B3:      asm_next = B2;
                B2:      asm_next = B1;
                B1:      asm_next = B0;
                B0:      asm_next = CHK;
                CHK: begin
                    asm_next   = HUNT;
                    frame_good = (rx_shift == xor_acc);
                    chk_bad    = !frame_good;
                end
                default: asm_next = HUNT;
            endcase
        end else if (timeout) begin
            asm_next = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state <= HUNT;
            shadow    <= '0;
            xor_acc   <= '0;
            tmr       <= '0;
        end else begin
            asm_state <= asm_next;
            if (byte_stb || byte_err || asm_state == HUNT) tmr <= '0;
            else                                          tmr <= tmr + 1'b1;
            if (byte_stb) begin
                if (asm_state == HUNT) begin
                    xor_acc <= '0;
                end else if (asm_state != CHK) begin
                    shadow  <= {shadow[23:0], rx_shift};
                    xor_acc <= xor_acc ^ rx_shift;
                end
            end
        end
    end

    // ---------------- output register and counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            Tx_data       <= '0;
            Tx_valid      <= 1'b0;
            chk_err_cnt   <= '0;
            frame_err_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            // A handshake in the same cycle frees the slot, so the new word replaces it without a drop.
            if (frame_good && (!Tx_valid || Tx_ready)) begin
                Tx_data  <= shadow;
                Tx_valid <= 1'b1;
            end else if (Tx_valid && Tx_ready) begin
                Tx_valid <= 1'b0;
            end
            if (frame_good && Tx_valid && !Tx_ready) drop_cnt <= sat_inc(drop_cnt);
            if (chk_bad)  chk_err_cnt   <= sat_inc(chk_err_cnt);
            if (byte_err) frame_err_cnt <= sat_inc(frame_err_cnt);
        end
    end

endmodule

// File: tb/tb_uart_tx_word_assembler.sv
// Directed bench for uart_tx_word_assembler: expected words go into a scoreboard queue,
// a monitor pops and compares on every Tx handshake; counters and levels are checked inline.
module tb_uart_tx_word_assembler;

    localparam int CPB = 16;
    localparam int TOB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic [31:0] Tx_data;
    logic        Tx_valid;
    logic        Tx_ready;
    logic [7:0]  chk_err_cnt, frame_err_cnt, drop_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          valid_cycles = 0;
    logic [31:0] exp_q[$];

    uart_tx_word_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_BYTES(TOB)) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx       (uart_rx),
        .Tx_data       (Tx_data),
        .Tx_valid      (Tx_valid),
        .Tx_ready      (Tx_ready),
        .chk_err_cnt   (chk_err_cnt),
        .frame_err_cnt (frame_err_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(CPB);
        end
        uart_rx = stop_bit;
        wait_clks(CPB);
        uart_rx = 1'b1;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 5; i >= 0; i--)
            send_byte(f[i*8 +: 8]);
        wait_clks(4);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_valid"}, 32'(Tx_valid), 32'd0);
        check({tag, "_tx_data"}, Tx_data, 32'd0);
        check({tag, "_chk_err"}, 32'(chk_err_cnt), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err_cnt), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1 && Tx_valid && Tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %h, expected no transfer", Tx_data);
                end else begin
                    check("tx_word", Tx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (Tx_valid) valid_cycles++;
        end
    end

    initial begin
        int vc0;
        rst      = 1'b1;
        uart_rx  = 1'b1;
        Tx_ready = 1'b0;
        wait_clks(4);
        check_reset_values("reset");
        rst = 1'b0;
        wait_clks(4);

        // 1: good frame, consumer ready
        Tx_ready = 1'b1;
        exp_q.push_back(32'h12345678);
        vc0 = valid_cycles;
        send_frame(48'hA5_12345678_08);
        check("t1_valid_width", 32'(valid_cycles - vc0), 32'd1);
        check("t1_chk_err", 32'(chk_err_cnt), 32'd0);
        check("t1_frame_err", 32'(frame_err_cnt), 32'd0);
        check("t1_drop", 32'(drop_cnt), 32'd0);

        // 2: bad checksum, then a good frame
        vc0 = valid_cycles;
        send_frame(48'hA5_12345678_09);
        check("t2_no_valid", 32'(valid_cycles - vc0), 32'd0);
        check("t2_chk_err", 32'(chk_err_cnt), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        send_frame(48'hA5_DEADBEEF_22);

        // 3: output occupied, second frame dropped
        Tx_ready = 1'b0;
        exp_q.push_back(32'h12345678);
        send_frame(48'hA5_12345678_08);
        send_frame(48'hA5_DEADBEEF_22);
        check("t3_valid_held", 32'(Tx_valid), 32'd1);
        check("t3_data_held", Tx_data, 32'h12345678);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        Tx_ready = 1'b1;
        wait_clks(1);
        check("t3_valid_fall", 32'(Tx_valid), 32'd0);

        // 4: stop-bit error returns to HUNT; a full frame follows immediately
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h3C, 1'b0);
        wait_clks(4);
        check("t4_frame_err", 32'(frame_err_cnt), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        send_frame(48'hA5_DEADBEEF_22);
        check("t4_chk_after_err", 32'(chk_err_cnt), 32'd1);
        // partial frame then long idle: timeout back to HUNT, no counter change
        send_byte(8'hA5);
        send_byte(8'h12);
        wait_clks(41 * 10 * CPB);
        check("t4_to_chk_err", 32'(chk_err_cnt), 32'd1);
        check("t4_to_frame_err", 32'(frame_err_cnt), 32'd1);
        check("t4_to_drop", 32'(drop_cnt), 32'd1);
        exp_q.push_back(32'hA5A5A5A5);
        send_frame(48'hA5_A5A5A5A5_00);
        check("t4_a5_chk_err", 32'(chk_err_cnt), 32'd1);

        // 5: short low glitch is a false start
        vc0 = valid_cycles;
        uart_rx = 1'b0;
        wait_clks(CPB / 4);
        uart_rx = 1'b1;
        wait_clks(30 * CPB);
        check("t5_glitch_frame_err", 32'(frame_err_cnt), 32'd1);
        check("t5_glitch_chk_err", 32'(chk_err_cnt), 32'd1);
        check("t5_glitch_valid", 32'(valid_cycles - vc0), 32'd0);
        // reset during D1
        send_byte(8'hA5);
        send_byte(8'h9A);
        send_byte(8'hBC);
        uart_rx = 1'b0;
        wait_clks(CPB);
        uart_rx = 1'b0;
        wait_clks(2 * CPB);
        rst     = 1'b1;
        uart_rx = 1'b1;
        wait_clks(3);
        check_reset_values("midrst");
        rst = 1'b0;
        wait_clks(4 * CPB);
        exp_q.push_back(32'h12345678);
        send_frame(48'hA5_12345678_08);
        check("t5_post_chk_err", 32'(chk_err_cnt), 32'd0);
        check("t5_post_frame_err", 32'(frame_err_cnt), 32'd0);

        wait_clks(10);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
